// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared opcode/funct constants, ALU op codes and register indices
package mips_pkg;
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_t;

   localparam logic [4:0] REG_ZERO = 5'd0;
   localparam logic [4:0] REG_T0 = 5'd8,  REG_T1 = 5'd9,  REG_T2 = 5'd10, REG_T3 = 5'd11;
   localparam logic [4:0] REG_T4 = 5'd12, REG_T5 = 5'd13, REG_T6 = 5'd14, REG_T7 = 5'd15;
   localparam logic [4:0] REG_S0 = 5'd16, REG_S1 = 5'd17, REG_S2 = 5'd18, REG_S3 = 5'd19;
   localparam logic [4:0] REG_S4 = 5'd20, REG_S5 = 5'd21, REG_S6 = 5'd22, REG_S7 = 5'd23;

   function automatic logic [31:0] sign_ext(input logic [15:0] imm);
      return {{16{imm[15]}}, imm};
   endfunction
endpackage

// File: rtl/mips_ifu.sv
// rtl/mips_ifu.sv - fetch unit: program counter register and instruction memory
module mips_ifu #(
   parameter int IMEM_BYTES = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_next,
   output logic [31:0] pc,
   output logic [31:0] instr
);
   localparam int IW = $clog2(IMEM_BYTES) - 2;

   logic [31:0] pc_q, pc_d;

   always_comb pc_d = pc_next;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) pc_q <= '0;
      else     pc_q <= pc_d;
   end

   assign pc = pc_q;

   mips_imem #(.BYTES(IMEM_BYTES)) imemory (
      .clk       (clk),
      .word_addr (pc_q[IW+1:2]),
      .rdata     (instr)
   );
endmodule

// File: rtl/mips_imem.sv
// rtl/mips_imem.sv - read-only instruction memory wrapper, contents loaded externally
module mips_imem #(
   parameter int BYTES = 1024,
   parameter int WW    = $clog2(BYTES) - 2
) (
   input  logic          clk,
   input  logic [WW-1:0] word_addr,
   output logic [31:0]   rdata
);
   mips_storage #(.BYTES(BYTES)) storage (
      .clk   (clk),
      .we    (1'b0),
      .waddr ('0),
      .raddr (word_addr),
      .wdata ('0),
      .rdata (rdata)
   );
endmodule

// File: rtl/mips_storage.sv
// rtl/mips_storage.sv - byte-array memory with big-endian word read and word write
module mips_storage #(
   parameter int BYTES = 1024,
   parameter int WW    = $clog2(BYTES) - 2
) (
   input  logic          clk,
   input  logic          we,
   input  logic [WW-1:0] waddr,
   input  logic [WW-1:0] raddr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);
   logic [7:0] bytes [0:BYTES-1];

   always_ff @(posedge clk) begin
      if (we) begin
         bytes[{waddr, 2'd0}] <= wdata[31:24];
         bytes[{waddr, 2'd1}] <= wdata[23:16];
         bytes[{waddr, 2'd2}] <= wdata[15:8];
         bytes[{waddr, 2'd3}] <= wdata[7:0];
      end
   end

   assign rdata = {bytes[{raddr, 2'd0}], bytes[{raddr, 2'd1}],
                   bytes[{raddr, 2'd2}], bytes[{raddr, 2'd3}]};
endmodule

// File: rtl/reg_file.sv
// rtl/reg_file.sv - 32x32 register file, two async reads, one sync write, async reset
module reg_file
   import mips_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  raddr1,
   input  logic [4:0]  raddr2,
   output logic [31:0] rdata1,
   output logic [31:0] rdata2,
   input  logic        we,
   input  logic [4:0]  waddr,
   input  logic [31:0] wdata
);
   logic [31:0] registers [0:31];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) registers[i] <= '0;
      end else if (we && waddr != REG_ZERO) begin
         registers[waddr] <= wdata;
      end
   end

   assign rdata1 = (raddr1 == REG_ZERO) ? '0 : registers[raddr1];
   assign rdata2 = (raddr2 == REG_ZERO) ? '0 : registers[raddr2];
endmodule

// File: rtl/mips_processor.sv
// rtl/mips_processor.sv - single-cycle MIPS core: decode, ALU, data memory, write-back, next PC
module mips_processor
   import mips_pkg::*;
#(
   parameter int IMEM_BYTES = 1024,
   parameter int DMEM_BYTES = 1024
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] pc,
   output logic [31:0] instr
);
   localparam int DW = $clog2(DMEM_BYTES) - 2;

   logic [5:0]  op, funct;
   logic [4:0]  rs, rt, rd, wa;
   logic [31:0] simm, rs_val, rt_val, alu_b, alu_y, mem_rdata, wb_data, pc_plus4, pc_next;
   logic        reg_we, mem_we, mem_to_reg, use_imm, branch, jump;
   alu_op_t     alu_op;

   mips_ifu #(.IMEM_BYTES(IMEM_BYTES)) IFU (
      .clk(clk), .rst(reset), .pc_next(pc_next), .pc(pc), .instr(instr)
   );

   assign op    = instr[31:26];
   assign rs    = instr[25:21];
   assign rt    = instr[20:16];
   assign rd    = instr[15:11];
   assign funct = instr[5:0];
   assign simm  = sign_ext(instr[15:0]);

   // Anything not decoded below falls through the defaults and behaves as a NOP.
   always_comb begin
      reg_we     = 1'b0;
      wa         = rd;
      alu_op     = ALU_ADD;
      use_imm    = 1'b0;
      mem_we     = 1'b0;
      mem_to_reg = 1'b0;
      branch     = 1'b0;
      jump       = 1'b0;
      case (op)
         OP_RTYPE: begin
            reg_we = 1'b1;
            case (funct)
               FN_ADD:  alu_op = ALU_ADD;
               FN_SUB:  alu_op = ALU_SUB;
               FN_AND:  alu_op = ALU_AND;
               FN_OR:   alu_op = ALU_OR;
               FN_SLT:  alu_op = ALU_SLT;
               default: reg_we = 1'b0;
            endcase
         end
         OP_ADDI: begin reg_we = 1'b1; wa = rt; use_imm = 1'b1; end
         OP_LW:   begin reg_we = 1'b1; wa = rt; use_imm = 1'b1; mem_to_reg = 1'b1; end
         OP_SW:   begin mem_we = 1'b1; use_imm = 1'b1; end
         OP_BEQ:  branch = 1'b1;
         OP_J:    jump = 1'b1;
         default: ;
      endcase
   end

   assign alu_b = use_imm ? simm : rt_val;

   always_comb begin
      case (alu_op)
         ALU_SUB: alu_y = rs_val - alu_b;
         ALU_AND: alu_y = rs_val & alu_b;
         ALU_OR:  alu_y = rs_val | alu_b;
         ALU_SLT: alu_y = {31'd0, $signed(rs_val) < $signed(alu_b)};
         default: alu_y = rs_val + alu_b;
      endcase
   end

   reg_file registers (
      .clk(clk), .rst(reset),
      .raddr1(rs), .raddr2(rt), .rdata1(rs_val), .rdata2(rt_val),
      .we(reg_we), .waddr(wa), .wdata(wb_data)
   );

   // Stores are held off while in reset so a reset spanning a clock edge has no side effects.
   mips_storage #(.BYTES(DMEM_BYTES)) dmemory (
      .clk   (clk),
      .we    (mem_we & ~reset),
      .waddr (alu_y[DW+1:2]),
      .raddr (alu_y[DW+1:2]),
      .wdata (rt_val),
      .rdata (mem_rdata)
   );

   assign wb_data  = mem_to_reg ? mem_rdata : alu_y;
   assign pc_plus4 = pc + 32'd4;
   assign pc_next  = jump                       ? {pc_plus4[31:28], instr[25:0], 2'b00} :
                     (branch && rs_val == rt_val) ? pc_plus4 + {simm[29:0], 2'b00} :
                     pc_plus4;
endmodule

// File: tb/tb_mips_processor.sv
// tb/tb_mips_processor.sv - directed and random programs checked against an ISA-level model
module tb_mips_processor;
   localparam int IMEM = 1024;
   localparam int DMEM = 1024;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] pc, instr;
   int          total = 0;
   int          bad = 0;

   logic [7:0]  m_im [IMEM];
   logic [7:0]  m_dm [DMEM];
   logic [31:0] m_r  [32];
   logic [31:0] m_pc;

   mips_processor #(.IMEM_BYTES(IMEM), .DMEM_BYTES(DMEM)) dut (
      .clk(clk), .reset(reset), .pc(pc), .instr(instr)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input logic [5:0] fn);
      return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
   endfunction

   function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input int imm);
      return {op, 5'(rs), 5'(rt), 16'(imm)};
   endfunction

   function automatic logic [31:0] enc_j(input int addr);
      return {6'h02, 26'(addr / 4)};
   endfunction

   task automatic put_word(input int a, input logic [31:0] w);
      m_im[a] = w[31:24]; m_im[a+1] = w[23:16]; m_im[a+2] = w[15:8]; m_im[a+3] = w[7:0];
      dut.IFU.imemory.storage.bytes[a]   = w[31:24];
      dut.IFU.imemory.storage.bytes[a+1] = w[23:16];
      dut.IFU.imemory.storage.bytes[a+2] = w[15:8];
      dut.IFU.imemory.storage.bytes[a+3] = w[7:0];
   endtask

   task automatic put_data(input int a, input logic [7:0] b);
      m_dm[a] = b;
      dut.dmemory.bytes[a] = b;
   endtask

   task automatic clear_imem();
      for (int a = 0; a < IMEM; a += 4) put_word(a, 32'd0);
   endtask

   task automatic m_reset();
      m_pc = 0;
      for (int i = 0; i < 32; i++) m_r[i] = 0;
   endtask

   function automatic logic [31:0] m_fetch();
      int a;
      a = int'(m_pc % 32'(IMEM)) / 4 * 4;
      return {m_im[a], m_im[a+1], m_im[a+2], m_im[a+3]};
   endfunction

   task automatic setr(input logic [4:0] idx, input logic [31:0] v);
      if (idx != 0) m_r[idx] = v;
   endtask

   // One instruction of architectural semantics, straight from the ISA rules.
   task automatic m_step();
      logic [31:0] w, a, b, simm, npc;
      logic [5:0]  op, fn;
      logic [4:0]  rs, rt, rd;
      int          ad;
      w = m_fetch();
      op = w[31:26]; rs = w[25:21]; rt = w[20:16]; rd = w[15:11]; fn = w[5:0];
      a = m_r[rs]; b = m_r[rt];
      simm = (w[15] == 1'b1) ? (32'hFFFF0000 | {16'd0, w[15:0]}) : {16'd0, w[15:0]};
      npc = m_pc + 4;
      ad = (int'((a + simm) % 32'(DMEM)) / 4) * 4;
      case (op)
         6'h00: case (fn)
            6'h20: setr(rd, a + b);
            6'h22: setr(rd, a - b);
            6'h24: setr(rd, a & b);
            6'h25: setr(rd, a | b);
            6'h2A: setr(rd, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
            default: ;
         endcase
         6'h08: setr(rt, a + simm);
         6'h23: setr(rt, {m_dm[ad], m_dm[ad+1], m_dm[ad+2], m_dm[ad+3]});
         6'h2B: begin
            m_dm[ad] = b[31:24]; m_dm[ad+1] = b[23:16]; m_dm[ad+2] = b[15:8]; m_dm[ad+3] = b[7:0];
         end
         6'h04: if (a == b) npc = m_pc + 4 + simm * 4;
         6'h02: npc = ((m_pc + 4) & 32'hF000_0000) | ((w & 32'h03FF_FFFF) * 4);
         default: ;
      endcase
      m_pc = npc;
   endtask

   task automatic run(input int n);
      repeat (n) begin
         check("pc", pc, m_pc);
         check("instr", instr, m_fetch());
         @(posedge clk);
         m_step();
         @(negedge clk);
         for (int i = 0; i < 32; i++)
            check($sformatf("r%0d", i), dut.registers.registers[i], m_r[i]);
      end
   endtask

   function automatic logic [31:0] rand_instr();
      logic [5:0] fns [5];
      fns[0] = 6'h20; fns[1] = 6'h22; fns[2] = 6'h24; fns[3] = 6'h25; fns[4] = 6'h2A;
      case ($urandom_range(0, 10))
         0, 1, 2, 3, 4: return enc_r($urandom_range(0, 23), $urandom_range(0, 23),
                                     $urandom_range(0, 23), fns[$urandom_range(0, 4)]);
         5: return enc_i(6'h08, $urandom_range(0, 23), $urandom_range(0, 23), int'($urandom));
         6: return enc_i(6'h23, $urandom_range(0, 23), $urandom_range(0, 23), int'($urandom));
         7: return enc_i(6'h2B, $urandom_range(0, 23), $urandom_range(0, 23), int'($urandom));
         8: return enc_i(6'h04, $urandom_range(0, 23), $urandom_range(0, 23), int'($urandom_range(0, 16)) - 8);
         9: return enc_j(4 * int'($urandom_range(0, 63)));
         default: return ($urandom_range(0, 1) == 1) ? {6'h3F, 26'($urandom)}
                                                      : enc_r($urandom_range(0, 23), $urandom_range(0, 23), 20, 6'h21);
      endcase
   endfunction

   initial begin
      clear_imem();
      for (int a = 0; a < DMEM; a++) put_data(a, 8'h00);
      put_word(0,  enc_i(6'h08, 0, 16, 10));
      put_word(4,  enc_i(6'h08, 0, 17, 374));
      put_word(8,  enc_i(6'h08, 0, 18, -34));
      put_word(12, enc_r(16, 17, 8,  6'h2A));
      put_word(16, enc_r(17, 16, 9,  6'h2A));
      put_word(20, enc_r(16, 16, 10, 6'h2A));
      put_word(24, enc_r(16, 18, 11, 6'h2A));
      put_word(28, enc_r(18, 16, 12, 6'h2A));
      put_word(32, enc_i(6'h2B, 0, 17, 8));
      put_word(36, enc_i(6'h23, 0, 13, 8));
      put_word(40, enc_i(6'h23, 0, 19, 32));
      put_word(44, enc_r(19, 19, 14, 6'h20));
      put_word(48, enc_r(0, 19, 15, 6'h22));
      put_word(52, enc_i(6'h04, 16, 16, 2));
      put_word(56, enc_i(6'h08, 0, 20, 1));
      put_word(60, enc_i(6'h08, 0, 21, 1));
      put_word(64, enc_i(6'h04, 16, 17, 5));
      put_word(68, enc_i(6'h08, 0, 0, 5));
      put_word(72, enc_r(16, 17, 22, 6'h24));
      put_word(76, enc_r(16, 17, 23, 6'h25));
      put_word(80, 32'hFC00_0000);
      put_word(84, enc_r(16, 17, 20, 6'h3F));
      put_word(88, enc_j(32'h40));
      put_data(32, 8'h7F); put_data(33, 8'hFF); put_data(34, 8'hFF); put_data(35, 8'hFF);
      m_reset();

      @(negedge clk);
      check("rst_pc", pc, 32'd0);
      for (int i = 0; i < 32; i++) check($sformatf("rst_r%0d", i), dut.registers.registers[i], 32'd0);
      reset = 1'b0;

      run(8);
      check("slt_s0", dut.registers.registers[16], 32'd10);
      check("slt_s1", dut.registers.registers[17], 32'd374);
      check("slt_s2", dut.registers.registers[18], 32'hFFFF_FFDE);
      check("slt_t0", dut.registers.registers[8],  32'd1);
      check("slt_t1", dut.registers.registers[9],  32'd0);
      check("slt_t2", dut.registers.registers[10], 32'd0);
      check("slt_t3", dut.registers.registers[11], 32'd0);
      check("slt_t4", dut.registers.registers[12], 32'd1);

      run(13);
      check("j_pc", pc, 32'h40);
      check("lw_t5", dut.registers.registers[13], 32'd374);
      check("sw_b8",  32'(dut.dmemory.bytes[8]),  32'h00);
      check("sw_b9",  32'(dut.dmemory.bytes[9]),  32'h00);
      check("sw_b10", 32'(dut.dmemory.bytes[10]), 32'h01);
      check("sw_b11", 32'(dut.dmemory.bytes[11]), 32'h76);
      check("add_wrap", dut.registers.registers[14], 32'hFFFF_FFFE);
      check("sub_wrap", dut.registers.registers[15], 32'h8000_0001);
      check("beq_skip_s4", dut.registers.registers[20], 32'd0);
      check("beq_skip_s5", dut.registers.registers[21], 32'd0);
      check("and_s6", dut.registers.registers[22], 32'd2);
      check("or_s7",  dut.registers.registers[23], 32'd382);
      check("zero_reg", dut.registers.registers[0], 32'd0);

      run(6);
      #2 reset = 1'b1;
      #1;
      check("mid_rst_pc", pc, 32'd0);
      for (int i = 0; i < 32; i++) check($sformatf("mid_rst_r%0d", i), dut.registers.registers[i], 32'd0);
      m_reset();
      @(negedge clk);
      reset = 1'b0;
      run(21);
      check("rerun_pc", pc, 32'h40);
      check("rerun_s0", dut.registers.registers[16], 32'd10);

      for (int a = 0; a < DMEM; a++) put_data(a, 8'($urandom));
      for (int p = 0; p < 3; p++) begin
         @(negedge clk);
         reset = 1'b1;
         clear_imem();
         for (int k = 0; k < 64; k++) put_word(4 * k, rand_instr());
         m_reset();
         @(negedge clk);
         reset = 1'b0;
         run(200);
         for (int a = 0; a < DMEM; a++)
            check($sformatf("dmem%0d", a), 32'(dut.dmemory.bytes[a]), 32'(m_dm[a]));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
